// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register_file write port between the ALU (req0)
// and load (req1) writeback paths, with a registered output stage and RAW hazard flags.
module regfile_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_reg,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_reg,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_reg,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_reg_1,
    input  logic [ADDR_WIDTH-1:0] rd_reg_2,
    output logic                  hazard_1,
    output logic                  hazard_2,
    output logic [CNT_WIDTH-1:0]  x0_drop_cnt
);

    // Handshake: a write transfers when reqN_valid && reqN_ready at a rising edge;
    // ready is combinational, never high for both requesters, and low during reset.
    logic                  r_last_grant;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_reg;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [CNT_WIDTH-1:0]  r_x0_cnt;

    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_xfer;
    logic [ADDR_WIDTH-1:0] w_acc_reg;
    logic [DATA_WIDTH-1:0] w_acc_data;
    logic                  w_acc_x0;
    logic                  w_wr_en;

    // On conflict the requester not granted last time wins; last_grant resets to 1.
    assign w_grant0   = !rst && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1   = !rst && req1_valid && (!req0_valid || !r_last_grant);
    assign w_xfer     = w_grant0 || w_grant1;
    assign w_acc_reg  = w_grant0 ? req0_reg  : req1_reg;
    assign w_acc_data = w_grant0 ? req0_data : req1_data;
    assign w_acc_x0   = (w_acc_reg == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_wr_en      <= 1'b0;
            r_wr_reg     <= '0;
            r_wr_data    <= '0;
            r_x0_cnt     <= '0;
        end else if (w_xfer) begin
            r_last_grant <= w_grant1;
            r_wr_en      <= !w_acc_x0;
            r_wr_reg     <= w_acc_reg;
            r_wr_data    <= w_acc_data;
            if (w_acc_x0 && (r_x0_cnt != '1)) begin
                r_x0_cnt <= r_x0_cnt + 1'b1;
            end
        end else begin
            r_wr_en <= 1'b0;
        end
    end

    // Gating with rst keeps an in-flight write from committing at the reset edge.
    assign w_wr_en = r_wr_en && !rst;

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign wr_en       = w_wr_en;
    assign wr_reg      = r_wr_reg;
    assign wr_data     = r_wr_data;
    assign x0_drop_cnt = r_x0_cnt;
    assign hazard_1    = w_wr_en && (rd_reg_1 == r_wr_reg) && (rd_reg_1 != '0);
    assign hazard_2    = w_wr_en && (rd_reg_2 == r_wr_reg) && (rd_reg_2 != '0);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: a behavioural register file sits on the write
// port, and a negedge monitor pops expected {reg,data} writes from a queue.
module tb_regfile_wr_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] req0_reg, req1_reg;
    logic [DW-1:0] req0_data, req1_data;
    logic          wr_en;
    logic [AW-1:0] wr_reg;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_reg_1, rd_reg_2;
    logic          hazard_1, hazard_2;
    logic [CW-1:0] x0_drop_cnt;

    logic [DW-1:0]    rf [32];
    logic [AW+DW-1:0] exp_q [$];
    int checks   = 0;
    int failures = 0;

    regfile_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg), .req1_data(req1_data),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_reg_1(rd_reg_1), .rd_reg_2(rd_reg_2),
        .hazard_1(hazard_1), .hazard_2(hazard_2),
        .x0_drop_cnt(x0_drop_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    // register_file model: commits on wr_en, x0 hardwired to zero
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(posedge clk) if (wr_en && wr_reg != '0) rf[wr_reg] <= wr_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every presented write must match the oldest expected write
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got reg %0d data %0h, expected no write", wr_reg, wr_data);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                if ({wr_reg, wr_data} !== e) begin
                    failures++;
                    $display("FAIL write_order: got reg %0d data %0h expected reg %0d data %0h",
                             wr_reg, wr_data, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    // driver: one cycle of request inputs with hand-computed expected grants
    task automatic drive(input logic v0, input logic [AW-1:0] r0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] r1, input logic [DW-1:0] d1,
                         input logic e0, input logic e1);
        req0_valid = v0; req0_reg = r0; req0_data = d0;
        req1_valid = v1; req1_reg = r1; req1_data = d1;
        @(negedge clk);
        chk("req0_ready", {63'd0, req0_ready}, {63'd0, e0});
        chk("req1_ready", {63'd0, req1_ready}, {63'd0, e1});
        @(posedge clk); #1;
        if (e0 && r0 != '0) exp_q.push_back({r0, d0});
        if (e1 && r1 != '0) exp_q.push_back({r1, d1});
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_reg = 5'd4; req0_data = 32'h1;
        req1_valid = 1'b1; req1_reg = 5'd6; req1_data = 32'h2;
        rd_reg_1 = '0; rd_reg_2 = '0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_req0_ready", {63'd0, req0_ready}, 64'd0);
            chk("rst_req1_ready", {63'd0, req1_ready}, 64'd0);
            @(posedge clk); #1;
            chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
            chk("rst_x0_cnt", {60'd0, x0_drop_cnt}, 64'd0);
        end
        chk("rst_wr_reg", {59'd0, wr_reg}, 64'd0);
        chk("rst_wr_data", {32'd0, wr_data}, 64'd0);
        rst = 1'b0;
        idle();
        chk("idle_wr_en", {63'd0, wr_en}, 64'd0);

        // conflict right after reset: 0,1,0,1
        drive(1'b1, 5'd3, 32'hA000_0003, 1'b1, 5'd7, 32'hB000_0007, 1'b1, 1'b0);
        chk("rr_wr_en0", {63'd0, wr_en}, 64'd1);
        drive(1'b1, 5'd3, 32'hA100_0003, 1'b1, 5'd7, 32'hB000_0007, 1'b0, 1'b1);
        chk("rr_wr_en1", {63'd0, wr_en}, 64'd1);
        drive(1'b1, 5'd3, 32'hA100_0003, 1'b1, 5'd7, 32'hB100_0007, 1'b1, 1'b0);
        chk("rr_wr_en2", {63'd0, wr_en}, 64'd1);
        drive(1'b1, 5'd3, 32'hA200_0003, 1'b1, 5'd7, 32'hB100_0007, 1'b0, 1'b1);
        chk("rr_wr_en3", {63'd0, wr_en}, 64'd1);

        // single writer
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("single_wr_en", {63'd0, wr_en}, 64'd1);
        chk("single_wr_reg", {59'd0, wr_reg}, 64'd5);
        chk("single_wr_data", {32'd0, wr_data}, {32'd0, 32'hDEAD_BEEF});
        idle();
        chk("single_wr_en_off", {63'd0, wr_en}, 64'd0);
        chk("rf_x5", {32'd0, rf[5]}, {32'd0, 32'hDEAD_BEEF});
        chk("rf_x3", {32'd0, rf[3]}, {32'd0, 32'hA100_0003});
        chk("rf_x7", {32'd0, rf[7]}, {32'd0, 32'hB100_0007});

        // x0 drops
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
            chk("x0_wr_en", {63'd0, wr_en}, 64'd0);
        end
        chk("x0_cnt3", {60'd0, x0_drop_cnt}, 64'd3);
        chk("rf_x0", {32'd0, rf[0]}, 64'd0);

        // hazard against the write in flight
        drive(1'b1, 5'd10, 32'hCAFE_0010, 1'b0, '0, '0, 1'b1, 1'b0);
        req0_valid = 1'b0;
        rd_reg_1 = 5'd10; rd_reg_2 = 5'd0; #1;
        chk("hazard_1_hit", {63'd0, hazard_1}, 64'd1);
        chk("hazard_2_x0", {63'd0, hazard_2}, 64'd0);
        chk("rf_x10_old", {32'd0, rf[10]}, 64'd0);
        rd_reg_2 = 5'd10; #1;
        chk("hazard_2_hit", {63'd0, hazard_2}, 64'd1);
        rd_reg_2 = 5'd0;
        idle();
        chk("hazard_1_clear", {63'd0, hazard_1}, 64'd0);
        chk("rf_x10_new", {32'd0, rf[10]}, {32'd0, 32'hCAFE_0010});
        rd_reg_1 = '0;

        // x0 counter saturation at 4'hF
        for (int i = 0; i < 14; i++) drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h0000_0001, 1'b0, 1'b1);
        chk("x0_cnt_sat", {60'd0, x0_drop_cnt}, 64'd15);

        // reset mid-flight cancels the pending write
        drive(1'b1, 5'd12, 32'h1234_5678, 1'b0, '0, '0, 1'b1, 1'b0);
        void'(exp_q.pop_back());
        rst = 1'b1; req0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("midrst_x0_cnt", {60'd0, x0_drop_cnt}, 64'd0);
        @(negedge clk);
        chk("rf_x12_kept", {32'd0, rf[12]}, 64'd0);
        @(posedge clk); #1;
        drive(1'b1, 5'd3, 32'h3333_3333, 1'b1, 5'd7, 32'h7777_7777, 1'b1, 1'b0);
        idle();
        idle();
        chk("rf_x3_after_rst", {32'd0, rf[3]}, {32'd0, 32'h3333_3333});
        chk("queue_drained", exp_q.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the single write port of register_file between two writeback requesters. Requester 0 is the ALU result path; requester 1 is the load-data path. Uses valid/ready handshakes, round-robin arbitration, and a registered output stage that drives wr_en/wr_reg/wr_data. Also reports read-after-write hazards against the write currently in flight, and counts dropped writes to x0.

Parameters:
DATA_WIDTH, 32, width of write data
ADDR_WIDTH, 5, register index width (32 registers)
CNT_WIDTH, 16, width of the x0-drop counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
req0_valid  input  1  requester 0 has a write pending
req0_ready  output  1  requester 0 write accepted this cycle
req0_reg  input  ADDR_WIDTH  requester 0 destination register
req0_data  input  DATA_WIDTH  requester 0 write data
req1_valid  input  1  requester 1 has a write pending
req1_ready  output  1  requester 1 write accepted this cycle
req1_reg  input  ADDR_WIDTH  requester 1 destination register
req1_data  input  DATA_WIDTH  requester 1 write data
wr_en  output  1  to register_file write enable
wr_reg  output  ADDR_WIDTH  to register_file write register
wr_data  output  DATA_WIDTH  to register_file write data
rd_reg_1  input  ADDR_WIDTH  register_file read index 1, monitored only
rd_reg_2  input  ADDR_WIDTH  register_file read index 2, monitored only
hazard_1  output  1  rd_reg_1 targets the write in flight
hazard_2  output  1  rd_reg_2 targets the write in flight
x0_drop_cnt  output  CNT_WIDTH  count of accepted writes to x0

Behaviour:
- Reset (rst=1 at posedge): wr_en=0, wr_reg=0, wr_data=0, x0_drop_cnt=0, last_grant=1.
  - While rst=1: req0_ready=0 and req1_ready=0 (combinational gating), and nothing is accepted.
- Handshake:
  - A transfer occurs when reqN_valid && reqN_ready at a posedge.
  - Ready is combinational from valid and last_grant, and is asserted for at most one requester per cycle.
  - A requester must hold reg/data stable while valid && !ready.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: grant goes to the requester not in last_grant.
  - Neither valid: no grant.
  - On every transfer, last_grant <= the granted index. After reset, req0 wins the first conflict.
- Output stage, 1-cycle latency:
  - At the transfer posedge: wr_reg <= reqN_reg, wr_data <= reqN_data, wr_en <= (reqN_reg != 0).
  - register_file commits the data at the following posedge.
  - Cycles with no transfer: wr_en <= 0. wr_reg and wr_data hold their last values.
- Throughput: one write per cycle sustained; register_file never backpressures.
- x0 writes:
  - Accepted normally (ready asserted) but never forwarded, so wr_en stays 0.
  - x0_drop_cnt increments by 1 per such transfer and saturates at all-ones (no wrap).
- Hazards (combinational): hazard_k = wr_en && (rd_reg_k == wr_reg) && (rd_reg_k != 0).
  - Meaning: a combinational read of rd_reg_k in this cycle returns the pre-write value.
- Back-to-back writes to the same register: each is committed in acceptance order. The last accepted write wins.
- Reset mid-operation: an in-flight output-stage write is cancelled (wr_en=0 next cycle). It is not committed.
- No other state. No FIFO: an unaccepted request stays with its requester.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all valids 0 -> wr_en=0, both readys 0 during reset, x0_drop_cnt=0. After reset, an idle cycle keeps wr_en=0.
- Single writer: req0 valid, reg=5, data=32'hDEADBEEF for 1 cycle -> req0_ready=1. Next cycle wr_en=1, wr_reg=5, wr_data=DEADBEEF. Following cycle register_file x5 reads DEADBEEF and wr_en=0.
- Conflict round-robin: both valid continuously with distinct regs 3 and 7 -> grants alternate 0,1,0,1. Each ready is high every other cycle, and wr_en stays 1 every cycle after the first.
- x0 drop: req1 valid, reg=0, data=32'hFFFFFFFF, 3 transfers -> req1_ready=1 each time, wr_en stays 0, x0 still reads 0, x0_drop_cnt=3.
- Hazard: accept a write to reg 10 and drive rd_reg_1=10, rd_reg_2=0 in the next cycle -> hazard_1=1, hazard_2=0. One cycle later hazard_1=0 and rd_data_1 shows the new data.
- Reset mid-flight: accept a write to reg 12 with data=32'h12345678 and assert rst at the next posedge -> wr_en=0 after reset, x12 unchanged. Requester 0 wins the next conflict.
